// File: rtl/wishbone_urom_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the unified ROM data port.
// Optional stalled-strobe timeout/abort is enabled with `define UROM_ARB_TIMEOUT_EN.
module wishbone_urom_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_M0_CYC,
    input  logic                  i_M0_STB,
    input  logic [ADDR_WIDTH-1:0] i_M0_ADDR,
    input  logic [3:0]            i_M0_SEL,
    output logic [DATA_WIDTH-1:0] o_M0_DATA,
    output logic                  o_M0_ACK,
    output logic                  o_M0_ERR,
    input  logic                  i_M1_CYC,
    input  logic                  i_M1_STB,
    input  logic [ADDR_WIDTH-1:0] i_M1_ADDR,
    input  logic [3:0]            i_M1_SEL,
    output logic [DATA_WIDTH-1:0] o_M1_DATA,
    output logic                  o_M1_ACK,
    output logic                  o_M1_ERR,
    output logic                  o_S_CYC,
    output logic                  o_S_STB,
    output logic [ADDR_WIDTH-1:0] o_S_ADDR,
    output logic [3:0]            o_S_SEL,
    input  logic [DATA_WIDTH-1:0] i_S_DATA,
    input  logic                  i_S_ACK,
    output logic [1:0]            o_GRANT
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    logic                  sel1;
    logic                  granted;
    logic                  m_cyc, m_stb, other_cyc;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [3:0]            m_sel;
    logic                  m_ack;
    logic                  m_err;
    logic                  timeout;

    assign sel1      = (state_q == GNT1);
    assign granted   = (state_q == GNT0) || (state_q == GNT1);
    assign m_cyc     = sel1 ? i_M1_CYC  : i_M0_CYC;
    assign m_stb     = sel1 ? i_M1_STB  : i_M0_STB;
    assign m_addr    = sel1 ? i_M1_ADDR : i_M0_ADDR;
    assign m_sel     = sel1 ? i_M1_SEL  : i_M0_SEL;
    assign other_cyc = sel1 ? i_M0_CYC  : i_M1_CYC;

`ifdef UROM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive unanswered strobes; any state change restarts it.
    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (granted && m_cyc && m_stb && !i_S_ACK) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
            else                                      cnt_d   = cnt_q + 1'b1;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        o_S_CYC  = 1'b0;
        o_S_STB  = 1'b0;
        o_S_ADDR = '0;
        o_S_SEL  = '0;
        o_GRANT  = 2'b00;
        m_ack    = 1'b0;
        m_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_M0_CYC && i_M1_CYC) state_d = last_q ? GNT0 : GNT1;
                else if (i_M0_CYC)        state_d = GNT0;
                else if (i_M1_CYC)        state_d = GNT1;
            end
            GNT0, GNT1: begin
                o_S_CYC  = m_cyc;
                o_S_STB  = m_stb;
                o_S_ADDR = m_addr;
                o_S_SEL  = m_sel;
                o_GRANT  = sel1 ? 2'b10 : 2'b01;
                m_ack    = i_S_ACK & m_stb;
                // Release hands over directly when the other master is waiting.
                if (!m_cyc) begin
                    last_d  = sel1;
                    state_d = other_cyc ? (sel1 ? GNT0 : GNT1) : IDLE;
                end else if (timeout) begin
                    m_err   = 1'b1;
                    o_S_CYC = 1'b0;
                    o_S_STB = 1'b0;
                    last_d  = sel1;
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!(last_q ? i_M1_CYC : i_M0_CYC)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign o_M0_ACK  = m_ack & ~sel1;
    assign o_M1_ACK  = m_ack &  sel1;
    assign o_M0_DATA = o_M0_ACK ? i_S_DATA : '0;
    assign o_M1_DATA = o_M1_ACK ? i_S_DATA : '0;

`ifdef UROM_ARB_TIMEOUT_EN
    assign o_M0_ERR = m_err & ~sel1;
    assign o_M1_ERR = m_err &  sel1;
`else
    assign o_M0_ERR = 1'b0;
    assign o_M1_ERR = 1'b0;
`endif

endmodule
